// File: rtl/spi_share_arbiter_pkg.sv
// Shared types and helpers for the SPI shifter sharing arbiter.
package spi_share_arbiter_pkg;

    localparam int ByteW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } arb_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_share_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter
    import spi_share_arbiter_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            any_valid_o
);

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        idx_o       = ptr_i;
        any_valid_o = |valid_i;
        for (int k = N - 1; k >= 0; k--) begin
            idx_o = valid_i[(int'(ptr_i) + k) % N] ? IdxW'((int'(ptr_i) + k) % N) : idx_o;
        end
    end

endmodule

// File: rtl/spi_share_arbiter.sv
// Shares one byte-wide SPI shifter between NumReq requesters with packet-long grants.
// Optional stall release of a silent requester: define SPI_ARB_TIMEOUT_EN.
module spi_share_arbiter
    import spi_share_arbiter_pkg::*;
#(
    parameter  int NumReq     = 4,
    parameter  int CsSetupCyc = 2,
    parameter  int CsHoldCyc  = 2,
    parameter  int IdleGapCyc = 1,
    parameter  int TimeoutCyc = 64,
    localparam int GrantW     = $clog2(NumReq)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [NumReq*ByteW-1:0]   req_data_i,
    input  logic [NumReq-1:0]         req_last_i,
    output logic [NumReq-1:0]         req_ready_o,
    output logic [NumReq-1:0]         rsp_valid_o,
    output logic [ByteW-1:0]          rsp_data_o,
    output logic                      spi_valid_o,
    output logic [ByteW-1:0]          spi_data_o,
    input  logic                      spi_ready_i,
    input  logic                      spi_rsp_valid_i,
    input  logic [ByteW-1:0]          spi_rsp_data_i,
    output logic [NumReq-1:0]         cs_no,
    output logic                      busy_o,
    output logic [GrantW-1:0]         grant_o,
    output logic                      timeout_o
);

    localparam int MaxCyc = max_int(max_int(CsSetupCyc, CsHoldCyc), max_int(IdleGapCyc, TimeoutCyc));
    localparam int CntW   = $clog2(MaxCyc + 1);
    localparam logic [CntW-1:0] SetupLd   = CntW'(CsSetupCyc - 1);
    localparam logic [CntW-1:0] HoldLd    = CntW'(CsHoldCyc - 1);
    localparam logic [CntW-1:0] GapLd     = CntW'(IdleGapCyc - 1);
    localparam logic [CntW-1:0] TimeoutLd = CntW'(TimeoutCyc - 1);

    arb_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   rr_ptr_q, rr_ptr_d;
    logic                last_q, last_d;
    logic [NumReq-1:0]   cs_n_q, cs_n_d;
    logic [NumReq-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ByteW-1:0]    rsp_data_q, rsp_data_d;
    logic                timeout_q, timeout_d;

    logic [GrantW-1:0]   arb_idx_s;
    logic                arb_any_s;
    logic                gnt_valid_s;
    logic                hs_s;

    rr_arbiter #(.N(NumReq)) u_rr (
        .valid_i     (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .idx_o       (arb_idx_s),
        .any_valid_o (arb_any_s)
    );

    // Byte path to the shifter is a pass-through of the granted requester while issuing.
    always_comb begin
        gnt_valid_s = req_valid_i[grant_q];
        hs_s        = 1'b0;
        spi_valid_o = 1'b0;
        spi_data_o  = 8'h00;
        req_ready_o = '0;
        if (state_q == ISSUE) begin
            spi_valid_o          = gnt_valid_s;
            spi_data_o           = req_data_i[grant_q*ByteW +: ByteW];
            hs_s                 = gnt_valid_s && spi_ready_i;
            req_ready_o[grant_q] = hs_s;
        end else begin
            spi_valid_o = 1'b0;
        end
    end

    // Packet sequencing; one shared down-counter times every phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    grant_d = arb_idx_s;
                    cs_n_d  = ~(NumReq'(1) << arb_idx_s);
                    cnt_d   = SetupLd;
                    state_d = SETUP;
                end else begin
                    cs_n_d = '1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = TimeoutLd;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ISSUE: begin
                if (hs_s) begin
                    last_d  = req_last_i[grant_q];
                    state_d = WAIT;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                // Only a silent requester ages the counter; a stalled shifter does not.
                else if (!gnt_valid_s) begin
                    if (cnt_q == '0) begin
                        last_d    = 1'b1;
                        timeout_d = 1'b1;
                        cnt_d     = HoldLd;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
`endif
                else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (spi_rsp_valid_i) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_data_d           = spi_rsp_data_i;
                    state_d              = last_q ? HOLD : ISSUE;
                    cnt_d                = last_q ? HoldLd : TimeoutLd;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d   = '1;
                    rr_ptr_d = (grant_q == GrantW'(NumReq - 1)) ? '0 : grant_q + GrantW'(1);
                    cnt_d    = GapLd;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                cs_n_d  = '1;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            last_q      <= 1'b0;
            cs_n_q      <= '1;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h00;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            last_q      <= last_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cs_no       = cs_n_q;
    assign busy_o      = (state_q != IDLE);
    assign grant_o     = grant_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Directed + randomized bench for spi_share_arbiter against a packet-level round-robin model.
module tb_spi_share_arbiter;

    localparam int NumReq     = 4;
    localparam int CsSetupCyc = 2;
    localparam int CsHoldCyc  = 2;
    localparam int IdleGapCyc = 1;
    localparam int TimeoutCyc = 64;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req_valid_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_last_i = '0;
    logic [3:0]  req_ready_o;
    logic [3:0]  rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        spi_valid_o;
    logic [7:0]  spi_data_o;
    logic        spi_ready_i = 1'b0;
    logic        spi_rsp_valid_i = 1'b0;
    logic [7:0]  spi_rsp_data_i = '0;
    logic [3:0]  cs_no;
    logic        busy_o;
    logic [1:0]  grant_o;
    logic        timeout_o;

    spi_share_arbiter #(
        .NumReq(NumReq), .CsSetupCyc(CsSetupCyc), .CsHoldCyc(CsHoldCyc),
        .IdleGapCyc(IdleGapCyc), .TimeoutCyc(TimeoutCyc)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .spi_valid_o(spi_valid_o), .spi_data_o(spi_data_o), .spi_ready_i(spi_ready_i),
        .spi_rsp_valid_i(spi_rsp_valid_i), .spi_rsp_data_i(spi_rsp_data_i),
        .cs_no(cs_no), .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // requester queues: {last, byte}
    logic [8:0] rq [4][$];
    int         exp_req_q [$];
    logic [7:0] exp_byte_q [$];
    int         model_ptr = 0;
    bit         drop [4];

    int         cycles = 0;
    bit         outstanding = 0, out_last = 0, hold_rsp = 0, force_nready = 0, force_spur = 0;
    logic [7:0] out_byte;
    int         out_req = 0, lat = 0;
    bit         rsp_exp = 0;
    int         rsp_exp_req = 0;
    logic [7:0] rsp_exp_data;
    logic [3:0] prev_cs = 4'hF;
    bit         setup_armed = 0, rise_pending = 0;
    int         fall_cycle = 0, rise_cycle = 0, rsp_last_cycle = 0;
    int         drop_arm = -1, to_req = -1, to_expect = -1;
    bit         to_arm = 0, to_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back({last, d});
    endtask

    task automatic add_packet(input int i, input int len);
        for (int j = 0; j < len; j++) push_byte(i, 8'($urandom), (j == len - 1));
    endtask

    // Expected byte stream: repeatedly serve one whole packet from the first
    // non-empty requester at/after the pointer, then move the pointer past it.
    task automatic plan();
        int pos [4];
        bit found;
        for (int i = 0; i < 4; i++) pos[i] = 0;
        do begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (model_ptr + k) % 4;
                if (!found && pos[i] < rq[i].size()) begin
                    found = 1;
                    do begin
                        exp_req_q.push_back(i);
                        exp_byte_q.push_back(rq[i][pos[i]][7:0]);
                        pos[i]++;
                    end while (!rq[i][pos[i]-1][8]);
                    model_ptr = (i + 1) % 4;
                end
            end
        end while (found);
    endtask

    function automatic bit any_work();
        bit w = 0;
        for (int i = 0; i < 4; i++) if (rq[i].size() != 0 && !drop[i]) w = 1;
        return w;
    endfunction

    task automatic tick();
        logic [3:0] oh, noh;
        int g;
        @(posedge clk_i); #1;
        cycles++;
        chk("timeout_o", 32'(timeout_o), 32'(cycles == to_expect));
        if (cycles == to_expect) begin
            to_seen = 1;
            rq[to_req].delete();
            exp_req_q.delete();
            exp_byte_q.delete();
            drop[to_req] = 0;
            model_ptr = (to_req + 1) % 4;
            rsp_last_cycle = cycles;
            to_expect = -1;
        end
        if (rsp_exp) begin
            oh = 4'b0001 << rsp_exp_req;
            chk("rsp_valid", 32'(rsp_valid_o), 32'(oh));
            chk("rsp_data", 32'(rsp_data_o), 32'(rsp_exp_data));
            rsp_exp = 0;
        end else begin
            chk("rsp_idle", 32'(rsp_valid_o), 32'd0);
        end
        chk("cs_at_most_one", 32'($countones(~cs_no) <= 1), 32'd1);
        if (prev_cs == 4'hF && cs_no != 4'hF) begin
            if (rise_pending) chk("idle_gap", 32'(cycles - rise_cycle), 32'(IdleGapCyc + 1));
            rise_pending = 0;
            setup_armed = 1;
            fall_cycle = cycles;
        end
        if (prev_cs != 4'hF && cs_no == 4'hF) begin
            chk("cs_hold", 32'(cycles - rsp_last_cycle), 32'(CsHoldCyc));
            rise_cycle = cycles;
            rise_pending = any_work();
        end
        prev_cs = cs_no;

        // drive requesters and the shifter model
        for (int i = 0; i < 4; i++) begin
            req_valid_i[i] = (rq[i].size() != 0) && !drop[i];
            req_data_i[i*8 +: 8] = (rq[i].size() != 0) ? rq[i][0][7:0] : 8'h00;
            req_last_i[i] = (rq[i].size() != 0) ? rq[i][0][8] : 1'b0;
        end
        spi_ready_i = force_nready ? 1'b0 : ($urandom_range(0, 3) != 0);
        spi_rsp_valid_i = 1'b0;
        spi_rsp_data_i = 8'h00;
        if (outstanding && !hold_rsp) begin
            if (lat == 0) begin
                spi_rsp_valid_i = 1'b1;
                spi_rsp_data_i = ~out_byte;
                rsp_exp = 1;
                rsp_exp_req = out_req;
                rsp_exp_data = ~out_byte;
                outstanding = 0;
                if (out_last) rsp_last_cycle = cycles + 1;
                if (to_arm) begin
`ifdef SPI_ARB_TIMEOUT_EN
                    to_expect = cycles + 1 + TimeoutCyc;
`endif
                    to_arm = 0;
                end
            end else begin
                lat--;
            end
        end else if (!outstanding && (force_spur || $urandom_range(0, 7) == 0)) begin
            spi_rsp_valid_i = 1'b1;
            spi_rsp_data_i = 8'($urandom);
        end
        #1;
        if (setup_armed && spi_valid_o) begin
            chk("cs_setup", 32'(cycles - fall_cycle), 32'(CsSetupCyc));
            setup_armed = 0;
        end
        if (outstanding) chk("spi_valid_in_wait", 32'(spi_valid_o), 32'd0);
        if (spi_valid_o && spi_ready_i) begin
            chk("byte_expected", 32'(exp_req_q.size() != 0), 32'd1);
            if (exp_req_q.size() != 0) begin
                g = exp_req_q.pop_front();
                out_byte = exp_byte_q.pop_front();
                oh = 4'b0001 << g;
                noh = ~oh;
                chk("req_ready", 32'(req_ready_o), 32'(oh));
                chk("spi_data", 32'(spi_data_o), 32'(out_byte));
                chk("grant", 32'(grant_o), 32'(g));
                chk("cs_sel", 32'(cs_no), 32'(noh));
                out_last = (rq[g].size() != 0) ? rq[g][0][8] : 1'b1;
                if (rq[g].size() != 0) void'(rq[g].pop_front());
                outstanding = 1;
                out_req = g;
                lat = $urandom_range(0, 3);
                if (g == drop_arm) begin
                    drop[g] = 1;
                    to_req = g;
                    drop_arm = -1;
                    to_arm = 1;
                end
            end
        end else begin
            chk("req_ready_idle", 32'(req_ready_o), 32'd0);
        end
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (exp_req_q.size() != 0 || outstanding || busy_o); n++) tick();
        chk("drain", 32'(exp_req_q.size()) + 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        req_valid_i = '0;
        spi_ready_i = 1'b0;
        spi_rsp_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
        cycles += n;
        chk("rst_cs", 32'(cs_no), 32'hF);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_spi_valid", 32'(spi_valid_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            drop[i] = 0;
        end
        exp_req_q.delete();
        exp_byte_q.delete();
        model_ptr = 0;
        outstanding = 0;
        rsp_exp = 0;
        hold_rsp = 0;
        prev_cs = 4'hF;
        setup_armed = 0;
        rise_pending = 0;
        to_expect = -1;
        drop_arm = -1;
        to_arm = 0;
    endtask

    initial begin
        // reset values
        do_reset(2);

        // req1 two-byte packet, shifter echoes inverted bytes
        push_byte(1, 8'hA5, 1'b0);
        push_byte(1, 8'h3C, 1'b1);
        plan();
        drain(200);
        chk("req1_last_rsp", 32'(rsp_data_o), 32'h0000_00C3);
        chk("req1_grant", 32'(grant_o), 32'd1);

        // req0 and req2 pending straight out of reset
        do_reset(1);
        add_packet(0, 2);
        add_packet(2, 3);
        plan();
        drain(300);
        chk("two_req_last_grant", 32'(grant_o), 32'd2);

        // req3 alone, then req0 and req3 together: pointer wraps to 0
        add_packet(3, 1);
        plan();
        drain(200);
        add_packet(0, 1);
        add_packet(3, 2);
        plan();
        drain(300);
        chk("wrap_last_grant", 32'(grant_o), 32'd3);

        // shifter stalls for 10 cycles in ISSUE
        add_packet(2, 3);
        plan();
        force_nready = 1;
        for (int n = 0; n < 20 && !spi_valid_o; n++) tick();
        chk("stall_reach_issue", 32'(spi_valid_o), 32'd1);
        repeat (10) tick();
        chk("stall_busy", 32'(busy_o), 32'd1);
        chk("stall_valid", 32'(spi_valid_o), 32'd1);
        force_nready = 0;
        drain(200);

        // reset while waiting on a response of a 4-byte packet
        add_packet(0, 4);
        plan();
        hold_rsp = 1;
        for (int n = 0; n < 40 && !outstanding; n++) tick();
        chk("reach_wait", 32'(outstanding), 32'd1);
        tick();
        tick();
        do_reset(1);
        force_spur = 1;
        repeat (3) tick();
        force_spur = 0;
        chk("post_rst_busy", 32'(busy_o), 32'd0);

        // granted requester drops valid after its first byte
        add_packet(1, 3);
        plan();
        drop_arm = 1;
`ifdef SPI_ARB_TIMEOUT_EN
        for (int n = 0; n < TimeoutCyc + 60 && !to_seen; n++) tick();
        chk("timeout_seen", 32'(to_seen), 32'd1);
        drain(60);
        chk("timeout_cs_release", 32'(cs_no), 32'hF);
`else
        repeat (80) tick();
        chk("silent_busy", 32'(busy_o), 32'd1);
        chk("silent_cs", 32'(cs_no), 32'hD);
        drop[1] = 0;
        drain(200);
`endif

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) add_packet(i, $urandom_range(1, 4));
            end
            plan();
            drain(800);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
